// File: rtl/cam_rgb444_capture.sv
`default_nettype none
// ============================================================================
// Module : cam_rgb444_capture
// Brief  : RGB444 byte-pair capture into a row-major frame buffer; the optional
//          sticky line-length error output is enabled by CAM_LINE_CHECK_EN.
// Rev    : 1.0
// ============================================================================
module cam_rgb444_capture #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic [7:0]    CAM_px_data,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [11:0]   DP_RAM_data_in,
  output logic          DP_RAM_regW,
  output logic          frame_done
`ifdef CAM_LINE_CHECK_EN
  ,
  output logic          line_err
`endif
);

  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);
  localparam logic [XW-1:0] c_IMG_W_X = XW'(IMG_W);
  localparam logic [YW-1:0] c_IMG_H_Y = YW'(IMG_H);
  localparam logic [AW-1:0] c_IMG_W_A = AW'(IMG_W);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_VSYNC   = 2'd1,
    S_BYTE_HI = 2'd2,
    S_BYTE_LO = 2'd3
  } state_t;

  state_t        r_state, w_next;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [AW-1:0] r_line_base;
  logic [3:0]    r_red;
  logic          r_line_active;
  logic          r_wrote_any;

  logic w_in_line, w_frame_end, w_byte, w_pix, w_line_end, w_in_win;

  assign w_in_line   = (r_state == S_BYTE_HI) || (r_state == S_BYTE_LO);
  assign w_frame_end = w_in_line && CAM_vsync;
  assign w_byte      = w_in_line && !CAM_vsync && CAM_href;
  assign w_pix       = (r_state == S_BYTE_LO) && w_byte;
  // href falling in BYTE_LO means an odd byte count; it still closes the line.
  assign w_line_end  = w_in_line && !CAM_vsync && !CAM_href &&
                       ((r_state == S_BYTE_LO) || r_line_active);
  assign w_in_win    = (r_x < c_IMG_W_X) && (r_y < c_IMG_H_Y);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (CAM_vsync) w_next = S_VSYNC;
      S_VSYNC:   if (!CAM_vsync) w_next = S_BYTE_HI;
      S_BYTE_HI: begin
        if (CAM_vsync)     w_next = S_VSYNC;
        else if (CAM_href) w_next = S_BYTE_LO;
      end
      S_BYTE_LO: w_next = CAM_vsync ? S_VSYNC : S_BYTE_HI;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x            <= '0;
      r_y            <= '0;
      r_line_base    <= '0;
      r_red          <= '0;
      r_line_active  <= 1'b0;
      r_wrote_any    <= 1'b0;
      DP_RAM_addr_in <= '0;
      DP_RAM_data_in <= '0;
      DP_RAM_regW    <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      DP_RAM_regW <= 1'b0;
      frame_done  <= w_frame_end && r_wrote_any;
      if (r_state == S_VSYNC) begin
        r_x           <= '0;
        r_y           <= '0;
        r_line_base   <= '0;
        r_line_active <= 1'b0;
        r_wrote_any   <= 1'b0;
      end
      if ((r_state == S_BYTE_HI) && w_byte) begin
        r_red         <= CAM_px_data[3:0];
        r_line_active <= 1'b1;
      end
      if (w_pix) begin
        if (w_in_win) begin
          DP_RAM_data_in <= {r_red, CAM_px_data};
          DP_RAM_addr_in <= r_line_base + AW'(r_x);
          DP_RAM_regW    <= 1'b1;
          r_wrote_any    <= 1'b1;
        end
        if (r_x != c_IMG_W_X) r_x <= r_x + 1'b1;
      end
      // y and line_base stop at the frame height so the base never wraps.
      if (w_line_end) begin
        r_line_active <= 1'b0;
        r_x           <= '0;
        if (r_y != c_IMG_H_Y) begin
          r_y         <= r_y + 1'b1;
          r_line_base <= r_line_base + c_IMG_W_A;
        end
      end
    end
  end

`ifdef CAM_LINE_CHECK_EN
  localparam int BW = $clog2(2 * IMG_W + 2);
  localparam logic [BW-1:0] c_LINE_BYTES = BW'(2 * IMG_W);

  logic [BW-1:0] r_bcnt;

  // Counter saturates one past a full line so long lines stay distinguishable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bcnt   <= '0;
      line_err <= 1'b0;
    end else if (r_state == S_VSYNC) begin
      r_bcnt   <= '0;
      line_err <= 1'b0;
    end else if (w_line_end) begin
      r_bcnt <= '0;
      if (r_bcnt != c_LINE_BYTES) line_err <= 1'b1;
    end else if (w_byte && (r_bcnt != c_LINE_BYTES + 1'b1)) begin
      r_bcnt <= r_bcnt + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire
